// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk datapath still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// CHUNK-bit ripple-carry slice; exposes the carry into its top bit for overflow.
// Latency: combinational.
// Backpressure: none, pure function of inputs.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock through one shared ripple slice.
// Latency: WIDTH/CHUNK+1 edges from accepted start to the done pulse.
// Backpressure: start is ignored (not queued) while busy; accepted again in the done cycle.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic             accept, last;

    logic [31:0]      base;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb;
    logic [WIDTH-1:0] s_nxt;

    // Slices are picked by shifting rather than part-selecting with the counter.
    assign base  = 32'(cnt) * 32'(CHUNK);
    assign sl_a  = CHUNK'(a_q >> base);
    assign sl_b  = CHUNK'(b_q >> base);
    assign s_nxt = (s & ~(WIDTH'({CHUNK{1'b1}}) << base)) | (WIDTH'(sl_s) << base);

    rca_chunk #(.CHUNK(CHUNK)) u_slice (
        .a        (sl_a),
        .b        (sl_b),
        .cin      (carry),
        .s        (sl_s),
        .cout     (sl_cout),
        .c_msb_in (sl_cmsb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(NCHUNK - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                // Subtraction is a + ~b + ~borrow, so fold sub into B and the carry.
                a_q   <= a;
                b_q   <= b ^ {WIDTH{sub}};
                carry <= cin ^ sub;
                s     <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                s     <= s_nxt;
                carry <= sl_cout;
                cnt   <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    cout <= sl_cout;
                    ovf  <= sl_cmsb ^ sl_cout;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder at CHUNK = 4, 1, 2, 16 sharing one stimulus stream,
// each checked cycle by cycle against a transaction-level arithmetic model.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy_w [4];
    logic        done_w [4];
    logic        cout_w [4];
    logic        ovf_w  [4];
    logic [15:0] s_w    [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int C = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : 16;
        chunked_serial_adder #(.WIDTH(16), .CHUNK(C)) u_dut (
            .clock (clk),
            .reset (rst),
            .start (start),
            .sub   (sub),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .busy  (busy_w[gi]),
            .done  (done_w[gi]),
            .s     (s_w[gi]),
            .cout  (cout_w[gi]),
            .ovf   (ovf_w[gi])
        );
    end

    int ch [4] = '{4, 1, 2, 16};

    // Model state: operation in flight, slices remaining, final answer, visible outputs.
    bit          mb   [4];
    int          mrem [4];
    bit          md   [4];
    logic [15:0] mres [4];
    logic [15:0] ms   [4];
    bit          mco  [4];
    bit          mov  [4];
    bit          nco  [4];
    bit          nov  [4];

    function automatic void ref_op(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb,
                                   output logic [15:0] r, output bit c, output bit o);
        longint ux, uy, sx, sy, lc, t, st;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lc = ci ? 64'sd1 : 64'sd0;
        if (!sb) begin
            t  = ux + uy + lc;
            st = sx + sy + lc;
            c  = (t > 65535);
        end else begin
            t  = ux - uy - lc;
            st = sx - sy - lc;
            c  = (t >= 0);
        end
        r = 16'(t);
        o = (st < -32768) || (st > 32767);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mb[i] = 1'b0; mrem[i] = 0; md[i] = 1'b0;
                ms[i] = '0;   mco[i] = 1'b0; mov[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                md[i] = 1'b0;
                if (mb[i]) begin
                    int bits;
                    mrem[i] = mrem[i] - 1;
                    bits    = (16 / ch[i] - mrem[i]) * ch[i];
                    ms[i]   = 16'(int'(mres[i]) & ((1 << bits) - 1));
                    if (mrem[i] == 0) begin
                        mb[i]  = 1'b0;
                        md[i]  = 1'b1;
                        mco[i] = nco[i];
                        mov[i] = nov[i];
                    end
                end else if (start) begin
                    ref_op(a, b, cin, sub, mres[i], nco[i], nov[i]);
                    mb[i]   = 1'b1;
                    mrem[i] = 16 / ch[i];
                    ms[i]   = '0;
                end
            end
        end
    end

    task automatic cmp(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d (CHUNK=%0d) at %0t: got %h want %h", nm, i, ch[i], $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            cmp("busy", i, 16'(busy_w[i]), 16'(mb[i]));
            cmp("done", i, 16'(done_w[i]), 16'(md[i]));
            cmp("s",    i, s_w[i],         ms[i]);
            cmp("cout", i, 16'(cout_w[i]), 16'(mco[i]));
            cmp("ovf",  i, 16'(ovf_w[i]),  16'(mov[i]));
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3]) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(k < 60), 32'd1);
    endtask

    // Directed op on the CHUNK=4 instance with literal expectations and timing.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int lat, bcnt;
        bcnt = 0;
        wait_idle();
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        while (!done_w[0] && lat < 40) begin
            if (busy_w[0]) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd5);
        chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd4);
        chk({nm, "_s"}, 32'(s_w[0]), 32'(es));
        chk({nm, "_cout"}, 32'(cout_w[0]), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf_w[0]), 32'(eo));
    endtask

    initial begin
        int nd, k, lat;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk); #2;
        chk("reset_busy", 32'(busy_w[0]), 32'd0);
        chk("reset_done", 32'(done_w[0]), 32'd0);
        chk("reset_s",    32'(s_w[0]),    32'd0);
        chk("reset_cout", 32'(cout_w[0]), 32'd0);
        chk("reset_ovf",  32'(ovf_w[0]),  32'd0);
        @(negedge clk); #2 rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, "sub_cin");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

        // Reset two cycles into RUN: everything returns to zero at once, no done follows.
        wait_idle();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_w[0]), 32'd0);
        chk("midrst_done", 32'(done_w[0]), 32'd0);
        chk("midrst_s",    32'(s_w[0]),    32'd0);
        chk("midrst_cout", 32'(cout_w[0]), 32'd0);
        chk("midrst_ovf",  32'(ovf_w[0]),  32'd0);
        @(negedge clk); #2 rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_w[0]) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "after_rst");

        // Extra start pulses while busy are dropped.
        wait_idle();
        @(negedge clk);
        a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_w[0]) nd++;
            @(negedge clk);
        end
        chk("ignore_done_count", 32'(nd), 32'd1);
        chk("ignore_s", 32'(s_w[0]), 32'h0303);

        // Start held through the done cycle launches a second op immediately.
        wait_idle();
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h1000; b = 16'h0234;
        k = 0;
        while (!done_w[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_s", 32'(s_w[0]), 32'h0003);
        @(negedge clk); start = 1'b0;
        lat = 1;
        while (!done_w[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_gap", 32'(lat), 32'd5);
        chk("b2b_second_s", 32'(s_w[0]), 32'h1234);

        // Random isolated operations.
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        // Random free-running start traffic with operands changing every cycle.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        @(negedge clk); start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
